// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
//   state_t : responder FSM encoding
//   op_t    : latched operation (read / write)
//   DATA_W  : word width, ADDR_PORT_W : width of the processor address port
package dmem_responder_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned ADDR_PORT_W = 16;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // A request with we set is a write, even when re is also set.
    function automatic op_t op_of(input logic we);
        return we ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor load/store port of the data-memory responder.
//   re, we, addr, wrt_data : request (processor -> memory)
//   rd_data, rdy, stall, err : response (memory -> processor)
// master = processor side, slave = responder side.
interface dmem_responder_if;
    import dmem_responder_pkg::*;

    logic                   re;
    logic                   we;
    logic [ADDR_PORT_W-1:0] addr;
    logic [DATA_W-1:0]      wrt_data;
    logic [DATA_W-1:0]      rd_data;
    logic                   rdy;
    logic                   stall;
    logic                   err;

    modport master (
        output re, we, addr, wrt_data,
        input  rd_data, rdy, stall, err
    );

    modport slave (
        input  re, we, addr, wrt_data,
        output rd_data, rdy, stall, err
    );

endinterface

// File: rtl/dmem_responder_array.sv
// dmem_array: synchronous single-port word RAM, 2^ADDR_W x DATA_W.
//   clk, rst_n : clock, async active-low reset (read register only)
//   wr_en      : write wr_data to addr on the rising edge
//   rd_en      : load rd_data from addr on the rising edge
//   rd_data    : registered read data, held between reads
// The storage itself has no reset.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;

    // Storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Registered read port; keeps its value until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[addr];
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the processor load/store port.
// Accepts one word read/write at a time, holds the processor with stall
// for LAT cycles, then completes with a one-cycle rdy pulse.
//   clk, rst_n : clock, async active-low reset
//   bus        : dmem_responder_if.slave (re/we/addr/wrt_data in,
//                rd_data/rdy/stall/err out; stall is combinational)
// Parameters: ADDR_W word-address bits (depth 2^ADDR_W), LAT latency 1..15.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LAT    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);

    localparam bit MULTI_CYCLE = (LAT > 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    op_t               op_q;
    logic              rdy_q;
    logic              err_q;

    logic              req_c;
    logic              accept_c;
    logic              live_c;
    logic [ADDR_W-1:0] acc_addr_c;
    logic [DATA_W-1:0] acc_wdata_c;
    op_t               acc_op_c;
    logic              mem_en_c;
    logic              unused_addr_hi;

    assign req_c    = bus.re | bus.we;
    assign accept_c = (state_q == IDLE) && req_c;

    // Upper address bits alias onto the implemented depth.
    assign unused_addr_hi = ^bus.addr[ADDR_PORT_W-1:ADDR_W];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = MULTI_CYCLE ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latency counter and request latches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
        end else if (accept_c) begin
            cnt_q   <= CNT_W'(LAT - 1);
            addr_q  <= bus.addr[ADDR_W-1:0];
            wdata_q <= bus.wrt_data;
            op_q    <= op_of(bus.we);
        end else if (state_q == BUSY) begin
            cnt_q   <= cnt_q - CNT_W'(1);
        end
    end

    // With LAT=1 the access happens on the acceptance edge itself, before
    // the latches are loaded, so the live request feeds the array in IDLE.
    assign live_c      = (state_q == IDLE);
    assign acc_addr_c  = live_c ? bus.addr[ADDR_W-1:0] : addr_q;
    assign acc_wdata_c = live_c ? bus.wrt_data : wdata_q;
    assign acc_op_c    = live_c ? op_of(bus.we) : op_q;
    assign mem_en_c    = (state_d == DONE) && (state_q != DONE);

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (mem_en_c && (acc_op_c == OP_WR)),
        .rd_en   (mem_en_c && (acc_op_c == OP_RD)),
        .addr    (acc_addr_c),
        .wr_data (acc_wdata_c),
        .rd_data (bus.rd_data)
    );

    // Completion and conflict pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= mem_en_c;
            err_q <= accept_c && bus.re && bus.we;
        end
    end

    assign bus.rdy   = rdy_q;
    assign bus.err   = err_q;
    assign bus.stall = accept_c || (state_q == BUSY);

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the processor's load/store port.
- The processor initiates 16-bit word reads and writes; this block accepts each request, holds the processor with `stall` for a fixed access latency, then completes with a one-cycle `rdy` pulse.
- Contains the word storage array, a small FSM and a latency counter.
- Sits beside the instruction-fetch path and answers requests issued from the execute stage.

Parameters:
- ADDR_W, 10, word-address bits used; depth = 2^ADDR_W words.
- LAT, 2, access latency in cycles from acceptance edge to `rdy` cycle; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- re  input  1  read request
- we  input  1  write request
- addr  input  16  word address; bits above ADDR_W-1 ignored
- wrt_data  input  16  write data
- rd_data  output  16  registered read data, valid in `rdy` cycle of a read and held afterwards
- rdy  output  1  one-cycle completion pulse
- stall  output  1  processor hold request
- err  output  1  one-cycle pulse: `re` and `we` were both high at acceptance

Behaviour:
- Reset (async, `rst_n` low):
  - FSM goes to IDLE; counter = 0.
  - `rd_data` = 16'h0000; `rdy` = 0; `err` = 0.
  - Storage array is NOT cleared.
- FSM states and transitions:
  - IDLE: waits for a request. If `re|we` is high at a rising edge, the request is accepted:
    - `addr[ADDR_W-1:0]`, `wrt_data` and the op (write if `we`, else read) are latched;
    - counter loads LAT-1;
    - next state is BUSY if LAT>1, else DONE.
  - BUSY: counter decrements each cycle. When counter = 1, next state is DONE.
  - DONE: lasts exactly one cycle, `rdy` = 1. Next state is always IDLE; a new request is not accepted in DONE.
- Memory access: performed on the edge entering DONE.
  - Write: `mem[latched addr]` gets latched `wrt_data`; `rd_data` is unchanged.
  - Read: `rd_data` gets `mem[latched addr]`.
- Timing: with acceptance at edge 0, `rdy` is high during cycle LAT (i.e. after edge LAT).
- stall: combinational = (IDLE & (`re|we`)) | BUSY. It is low in DONE so the processor advances in the `rdy` cycle.
- Initiator rules:
  - Request inputs need not be held after acceptance.
  - The initiator drops or changes its request after the `rdy` cycle.
  - A request still high in the cycle after DONE is treated as a new transaction.
- Simultaneous `re` & `we` at acceptance:
  - Executed as a write.
  - `err` pulses high in the cycle after acceptance.
- Address wrap: `addr` ≥ 2^ADDR_W aliases to `addr mod 2^ADDR_W`; no error is flagged.
- Back-to-back: minimum spacing between acceptances is LAT+1 cycles (one IDLE cycle between transactions).
- Read-after-write to the same address returns the new data.
- Reset mid-transaction: the transaction is aborted. A pending write is not performed; `rdy` is not issued; `stall` drops immediately.
- `rdy` and `err` are registered outputs; `stall` is the only combinational output.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'b00, BUSY=2'b01, DONE=2'b10);
  - data width constant DATA_W=16;
  - op encoding (OP_RD=1'b0, OP_WR=1'b1).
- One sub-module: `dmem_array`, a synchronous single-port RAM (depth 2^ADDR_W × 16, write enable, registered read).
- FSM, counter and request latches stay in `dmem_responder`.

Test Plan:
- Write then read, LAT=2.
  - Stimulus: write 16'hBEEF to addr 16'h0005; after `rdy`, read addr 16'h0005.
  - Required: `stall` high for 2 cycles each; `rdy` pulses at cycle 2 of each transaction; `rd_data` = 16'hBEEF.
- LAT=1 read.
  - Stimulus: preload addr 3 = 16'h1234; read addr 3.
  - Required: `rdy` in the cycle after acceptance; `stall` high for 1 cycle only; `rd_data` = 16'h1234.
- Address wrap, ADDR_W=10.
  - Stimulus: write 16'hA5A5 to addr 16'h0407; read addr 16'h0007.
  - Required: returns 16'hA5A5; `err` stays 0.
- Conflict.
  - Stimulus: `re`=`we`=1, addr 9, `wrt_data` 16'h0F0F.
  - Required: `err` = 1 for exactly one cycle; subsequent read of addr 9 returns 16'h0F0F.
- Reset mid-operation, LAT=4.
  - Stimulus: write 16'h7777 to addr 2 (addr 2 previously 16'h1111); drive `rst_n` low in cycle 2.
  - Required: `stall`=0 and `rdy`=0 immediately; `rd_data`=0; read of addr 2 returns 16'h1111.
- Held request.
  - Stimulus: hold `re`=1 at addr 1 for 10 cycles, LAT=2.
  - Required: `rdy` pulses at cycles 2 and 5 (a new acceptance every LAT+1 cycles); `stall` low only in `rdy` cycles.
